// File: rtl/shift_unit_seq_pkg.sv
// Shared constants, op encodings and FSM state type for the iterative shifter.
package shift_unit_seq_pkg;

  localparam int SU_WIDTH   = 32;
  localparam int SU_SHAMT_W = 5;

  // Op encodings as seen on the op input.
  localparam logic SHIFT_OP_SLL = 1'b0;
  localparam logic SHIFT_OP_SRA = 1'b1;

  // FSM states, exposed on the interface for observation.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } su_state_e;

  // Width of the stage index that counts SHAMT_W-1 down to 0.
  function automatic int stage_idx_w(input int shamt_w);
    return (shamt_w > 1) ? $clog2(shamt_w) : 1;
  endfunction

endpackage

// File: rtl/shift_unit_seq_if.sv
// Request/response bundle between the execute stage and the shift unit.
//
// Handshake: the requester drives start together with op/data_in/shamt.
// The unit accepts a request on a rising edge where start=1 and busy=0
// (IDLE or DONE state); operands are captured on that edge and may change
// freely afterwards. start while busy=1 is dropped, not queued. done is a
// single-cycle pulse; result is valid while done=1 and is held until the
// next accepted start. state mirrors the internal FSM for observation.
interface shift_unit_seq_if
  import shift_unit_seq_pkg::*;
#(
  parameter int WIDTH   = SU_WIDTH,
  parameter int SHAMT_W = SU_SHAMT_W
);
  logic               start;
  logic               op;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   result;
  logic               busy;
  logic               done;
  su_state_e          state;

  // Requester side (execute stage).
  modport master (
    output start, op, data_in, shamt,
    input  result, busy, done, state
  );

  // Shift unit side.
  modport slave (
    input  start, op, data_in, shamt,
    output result, busy, done, state
  );
endinterface

// File: rtl/shift_unit_seq_shift_stage.sv
// One binary-weighted shift stage: shifts by 2^sel when enabled, else passes.
module shift_stage
  import shift_unit_seq_pkg::*;
#(
  parameter int WIDTH   = SU_WIDTH,
  parameter int SHAMT_W = SU_SHAMT_W,
  parameter int SEL_W   = stage_idx_w(SU_SHAMT_W)
) (
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_op,
  input  logic             i_en,
  input  logic [SEL_W-1:0] i_sel,
  output logic [WIDTH-1:0] o_out
);

  // Stage weight 2^sel; one extra bit so the largest weight fits.
  logic [SHAMT_W:0] w_amt;
  assign w_amt = (SHAMT_W+1)'(1) << i_sel;

  // SRA replicates the current MSB, which is always the captured sign bit.
  always_comb begin
    o_out = i_in;
    if (i_en) begin
      if (i_op == SHIFT_OP_SRA) begin
        o_out = $signed(i_in) >>> w_amt;
      end else begin
        o_out = i_in << w_amt;
      end
    end
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Iterative 32-bit SLL/SRA shifter: one stage per cycle (16,8,4,2,1),
// fixed latency, start/done handshake.
module shift_unit_seq
  import shift_unit_seq_pkg::*;
#(
  parameter int WIDTH   = SU_WIDTH,
  parameter int SHAMT_W = SU_SHAMT_W
) (
  input logic             clock,
  input logic             reset,
  shift_unit_seq_if.slave bus
);

  localparam int K_W = stage_idx_w(SHAMT_W);
  localparam logic [K_W-1:0] K_FIRST = K_W'(SHAMT_W - 1);

  su_state_e          r_state;
  logic [WIDTH-1:0]   r_work;
  logic               r_op;
  logic [SHAMT_W-1:0] r_shamt;
  logic [K_W-1:0]     r_k;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_stage_out;
  logic               w_stage_en;
  logic               w_accept;

  // Requests are taken whenever the unit is not mid-shift.
  assign w_accept   = bus.start && (r_state != ST_SHIFT);
  assign w_stage_en = r_shamt[r_k];

  shift_stage #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W),
    .SEL_W   (K_W)
  ) u_stage (
    .i_in  (r_work),
    .i_op  (r_op),
    .i_en  (w_stage_en),
    .i_sel (r_k),
    .o_out (w_stage_out)
  );

  // Control FSM with capture, stage counter and registered busy/done.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_op    <= SHIFT_OP_SLL;
      r_shamt <= '0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state <= ST_SHIFT;
            r_work  <= bus.data_in;
            r_op    <= bus.op;
            r_shamt <= bus.shamt;
            r_k     <= K_FIRST;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_work <= w_stage_out;
          if (r_k == '0) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_k <= r_k - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result = r_work;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.state  = r_state;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed self-checking bench for shift_unit_seq.
module tb_shift_unit_seq;
  import shift_unit_seq_pkg::*;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  shift_unit_seq_if bus ();

  shift_unit_seq dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: present a request for one edge, then scramble the operands.
  task automatic issue(input logic op, input logic [31:0] d, input logic [4:0] s);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.data_in = d;
    bus.shamt   = s;
    tick();
    bus.start   = 1'b0;
    bus.op      = ~op;
    bus.data_in = ~d;
    bus.shamt   = ~s;
  endtask

  // Five busy cycles, then the done cycle with the expected result.
  task automatic finish(input string tag, input logic [31:0] exp);
    for (int i = 0; i < 5; i++) begin
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_nodone"}, 32'(bus.done), 32'd0);
      tick();
    end
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_result"}, bus.result, exp);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 1'b0;
    bus.data_in = '0;
    bus.shamt   = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'h0);
    check("rst_state", 32'(bus.state), 32'(ST_IDLE));
    tick();

    // SLL 1 by 31
    issue(SHIFT_OP_SLL, 32'h0000_0001, 5'd31);
    finish("sll31", 32'h8000_0000);
    tick();
    check("sll31_pulse", 32'(bus.done), 32'd0);
    check("sll31_hold", bus.result, 32'h8000_0000);
    check("sll31_idle", 32'(bus.state), 32'(ST_IDLE));

    // SRA cases
    issue(SHIFT_OP_SRA, 32'h8000_0000, 5'd16);
    finish("sra16", 32'hFFFF_8000);
    tick();
    issue(SHIFT_OP_SRA, 32'h7FFF_0000, 5'd4);
    finish("sra4", 32'h07FF_F000);
    tick();

    // Zero shift and full SRA
    issue(SHIFT_OP_SLL, 32'hDEAD_BEEF, 5'd0);
    finish("sll0", 32'hDEAD_BEEF);
    tick();
    issue(SHIFT_OP_SRA, 32'hF000_0000, 5'd31);
    finish("sra31", 32'hFFFF_FFFF);
    tick();

    // start while busy is ignored
    issue(SHIFT_OP_SLL, 32'h0000_000F, 5'd4);
    tick();
    bus.start   = 1'b1;
    bus.op      = SHIFT_OP_SRA;
    bus.data_in = 32'h1234_5678;
    bus.shamt   = 5'd3;
    tick();
    bus.start   = 1'b0;
    check("busystart_busy", 32'(bus.busy), 32'd1);
    tick();
    tick();
    tick();
    check("busystart_done", 32'(bus.done), 32'd1);
    check("busystart_result", bus.result, 32'h0000_00F0);
    tick();
    check("busystart_single", 32'(bus.done), 32'd0);
    check("busystart_idle", 32'(bus.busy), 32'd0);

    // Back-to-back: start in the done cycle
    issue(SHIFT_OP_SLL, 32'h0000_0003, 5'd2);
    finish("b2b_first", 32'h0000_000C);
    issue(SHIFT_OP_SRA, 32'hFFFF_FF00, 5'd8);
    check("b2b_state", 32'(bus.state), 32'(ST_SHIFT));
    finish("b2b_second", 32'hFFFF_FFFF);
    tick();

    // Reset mid-operation
    issue(SHIFT_OP_SLL, 32'h0000_0001, 5'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", bus.result, 32'h0);
    check("midrst_state", 32'(bus.state), 32'(ST_IDLE));
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_nodone", 32'(bus.done), 32'd0);
    end
    issue(SHIFT_OP_SRA, 32'h8000_0000, 5'd1);
    finish("post_rst", 32'hC000_0000);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
